vga_sync_gen: RTL

//  640x480@60 VGA timing generator and output register stage for the display path.

---
 rtl/vga_sync_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator with a one-pixel registered, blanked, sync-aligned output stage.
// Optional build macro VGA_SYNC_FRAME_CNT_EN adds frame_cnt/frame_start outputs.
`timescale 1ns/1ps

module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       video_on,
  output logic       pix_tick,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic       vga_vs,
  output logic [7:0] frame_cnt,
  output logic [0:0] frame_start
`else
  output logic       vga_vs
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             w_tick;
  logic             w_h_end;
  logic             w_v_end;
  logic             w_hs_raw;
  logic             w_vs_raw;

  // With CLK_DIV=1 the divider is pinned at 0 == DIV_LAST, so the tick is constantly high.
  assign w_tick   = (r_div_cnt == DIV_LAST);
  assign w_h_end  = (r_h_cnt == H_LAST);
  assign w_v_end  = (r_v_cnt == V_LAST);
  assign w_hs_raw = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign w_vs_raw = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));

  assign pix_tick = w_tick;
  assign x        = r_h_cnt;
  assign y        = r_v_cnt[8:0];
  assign video_on = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_h_cnt <= w_h_end ? '0 : r_h_cnt + 10'd1;
        if (w_h_end) r_v_cnt <= w_v_end ? '0 : r_v_cnt + 10'd1;
      end
    end
  end

  // Pins lag the counters by one pixel; colour and sync are captured together so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (w_tick) begin
      vga_r  <= video_on ? r_in : 4'h0;
      vga_g  <= video_on ? g_in : 4'h0;
      vga_b  <= video_on ? b_in : 4'h0;
      vga_hs <= w_hs_raw;
      vga_vs <= w_vs_raw;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  assign frame_start[0] = w_tick && w_h_end && w_v_end;
  assign frame_cnt      = r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst)                 r_frame_cnt <= '0;
    else if (frame_start[0]) r_frame_cnt <= r_frame_cnt + 8'd1;
  end
`endif

endmodule
